// File: rtl/video_hblur3_pkg.sv
// rtl/video_hblur3_pkg.sv - shared types and constants for the horizontal blur stage
// Holds the FSM state encoding, the video packet identifier and the RGB pixel layout.
package video_hblur3_pkg;

  typedef enum logic [1:0] {
    PASS,
    V_EMPTY,
    V_FULL,
    FLUSH
  } state_t;

  // Low nibble of a packet header word that marks a video packet.
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  // Matches the {R,G,B} beat layout on the stream.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/hblur3_kernel.sv
// rtl/hblur3_kernel.sv - combinational 1-2-1 horizontal kernel over three RGB pixels
// Ports:
//   l_pix  in  left neighbour
//   c_pix  in  centre pixel
//   r_pix  in  right neighbour
//   y_pix  out (l + 2c + r + 2) >> 2 per channel
module hblur3_kernel
  import video_hblur3_pkg::*;
(
  input  rgb_t l_pix,
  input  rgb_t c_pix,
  input  rgb_t r_pix,
  output rgb_t y_pix
);

  // Worst case is 4*255+2 = 1022, which fits in 10 bits; after the shift the
  // result is at most 255, so no saturation is needed.
  function automatic logic [7:0] k121(input logic [7:0] a, input logic [7:0] c, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, c, 1'b0} + {2'b00, b} + 10'd2;
    return s[9:2];
  endfunction

  assign y_pix.r = k121(l_pix.r, c_pix.r, r_pix.r);
  assign y_pix.g = k121(l_pix.g, c_pix.g, r_pix.g);
  assign y_pix.b = k121(l_pix.b, c_pix.b, r_pix.b);

endmodule

// File: rtl/video_hblur3.sv
// rtl/video_hblur3.sv - streaming 1x3 horizontal smoothing stage with packet passthrough
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   sink_data/valid/ready/sop/eop        upstream stream (24-bit {R,G,B})
//   source_data/valid/ready/sop/eop      downstream stream, registered
//   filt_en                              filter enable, sampled on each sop beat
module video_hblur3
  import video_hblur3_pkg::*;
#(
  parameter int IMAGE_W = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        filt_en
);

  localparam int XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);

  state_t        state, state_nx;
  rgb_t          h_pix, p_pix;
  logic [XW-1:0] h_x;
  logic          h_eop;

  rgb_t          kern_l, kern_r, kern_y;
  logic          free, accept, is_video_sop;
  logic          or_load, or_sop_d, or_eop_d;
  logic [23:0]   or_data_d;
  logic          h_first, h_shift;

  assign free         = ~source_valid | source_ready;
  assign accept       = sink_valid & sink_ready;
  assign is_video_sop = sink_sop & (sink_data[3:0] == PKT_VIDEO) & filt_en;

  // A sop seen while a pixel is still held must wait until that pixel has
  // been emitted, so the header is refused in V_FULL.
  always_comb begin
    sink_ready = 1'b0;
    if (reset_n) begin
      case (state)
        PASS, V_EMPTY: sink_ready = free;
        V_FULL:        sink_ready = free & ~sink_sop;
        default:       sink_ready = 1'b0;
      endcase
    end
  end

  // Neighbours replicate the held pixel at line edges, at end of packet and
  // when a truncating sop is pending, so adjacent lines never mix.
  always_comb begin
    kern_l = (h_x == '0) ? h_pix : p_pix;
    kern_r = h_pix;
    if (state == V_FULL && !sink_sop && h_x != X_LAST) begin
      kern_r = rgb_t'(sink_data);
    end
  end

  hblur3_kernel u_kernel (
    .l_pix (kern_l),
    .c_pix (h_pix),
    .r_pix (kern_r),
    .y_pix (kern_y)
  );

  always_comb begin
    state_nx  = state;
    or_load   = 1'b0;
    or_data_d = sink_data;
    or_sop_d  = sink_sop;
    or_eop_d  = sink_eop;
    h_first   = 1'b0;
    h_shift   = 1'b0;
    case (state)
      PASS: begin
        if (accept) begin
          or_load = 1'b1;
          if (is_video_sop) state_nx = V_EMPTY;
        end
      end
      V_EMPTY: begin
        if (accept) begin
          if (sink_sop) begin
            // Empty video packet followed by a new header: treat like PASS.
            or_load  = 1'b1;
            state_nx = is_video_sop ? V_EMPTY : PASS;
          end else begin
            h_first  = 1'b1;
            state_nx = sink_eop ? FLUSH : V_FULL;
          end
        end
      end
      V_FULL: begin
        if (accept) begin
          or_load   = 1'b1;
          or_data_d = kern_y;
          or_sop_d  = 1'b0;
          or_eop_d  = 1'b0;
          h_shift   = 1'b1;
          if (sink_eop) state_nx = FLUSH;
        end else if (sink_valid && sink_sop && free) begin
          or_load   = 1'b1;
          or_data_d = kern_y;
          or_sop_d  = 1'b0;
          or_eop_d  = 1'b0;
          state_nx  = PASS;
        end
      end
      FLUSH: begin
        if (free) begin
          or_load   = 1'b1;
          or_data_d = kern_y;
          or_sop_d  = 1'b0;
          or_eop_d  = h_eop;
          state_nx  = PASS;
        end
      end
      default: state_nx = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= PASS;
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      h_pix        <= '0;
      p_pix        <= '0;
      h_x          <= '0;
      h_eop        <= 1'b0;
    end else begin
      state <= state_nx;
      if (or_load) begin
        source_valid <= 1'b1;
        source_data  <= or_data_d;
        source_sop   <= or_sop_d;
        source_eop   <= or_eop_d;
      end else if (source_ready) begin
        source_valid <= 1'b0;
      end
      if (h_first) begin
        h_pix <= rgb_t'(sink_data);
        h_x   <= '0;
        h_eop <= sink_eop;
      end else if (h_shift) begin
        p_pix <= h_pix;
        h_pix <= rgb_t'(sink_data);
        h_x   <= (h_x == X_LAST) ? '0 : h_x + XW'(1);
        h_eop <= sink_eop;
      end
    end
  end

endmodule
